// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC generation, pipelined I-cache requests with per-request kill bits,
// credit-based instruction queue. Optional branch-predictor use under `FETCH_BP_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_VECTOR    = 32'h8000_0000,
  parameter int unsigned IBUF_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trap_i,
  input  logic [31:0]                 trap_vector_i,
  input  logic                        mret_i,
  input  logic [31:0]                 mret_vector_i,
  input  logic                        br_mispredict_i,
  input  logic [31:0]                 br_target_i,
  input  logic                        wfi_i,
  output logic [31:0]                 bp_pc_o,
  input  logic                        bp_hit_i,
  input  logic [31:0]                 bp_target_i,
  output logic                        icache_req_valid_o,
  input  logic                        icache_req_ready_i,
  output logic [31:0]                 icache_req_addr_o,
  input  logic                        icache_resp_valid_i,
  output logic                        icache_resp_ready_o,
  input  logic [31:0]                 icache_resp_data_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [31:0]                 instr_pc_o,
  output logic [31:0]                 instr_next_pc_o,
  output logic [31:0]                 instr_o,
  output logic                        instr_pred_taken_o,
  output logic                        instr_exc_o,
  output logic [3:0]                  instr_ecause_o,
  output logic [$clog2(IBUF_DEPTH):0] ibuf_count_o
);

  localparam int unsigned QW = $clog2(IBUF_DEPTH);
  localparam int unsigned CW = QW + 1;
  localparam int unsigned FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] data;
    logic        pred;
    logic        exc;
  } ent_t;

  logic [31:0]          pc;
  logic                 exc_stall;
  req_t                 fl_mem [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fl_kill;
  logic [FW-1:0]        fl_head, fl_tail;
  logic [IW-1:0]        inflight;
  ent_t                 q_mem [IBUF_DEPTH];
  logic [QW-1:0]        q_head, q_tail;
  logic [CW-1:0]        count;

  logic        redirect, credit_ok, req_valid, req_fire, resp_fire, resp_keep;
  logic        exc_push, q_push, q_pop, pred;
  logic [31:0] target, seq_pc, npc;
  ent_t        q_wdata, head;

  function automatic logic [FW-1:0] fl_next(input logic [FW-1:0] p);
    if (32'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + 1'b1;
  endfunction

  assign redirect = trap_i | mret_i | br_mispredict_i;
  assign target   = trap_i ? trap_vector_i : (mret_i ? mret_vector_i : br_target_i);
  assign seq_pc   = pc + 32'd4;

`ifdef FETCH_BP_EN
  assign npc  = bp_hit_i ? bp_target_i : seq_pc;
  assign pred = bp_hit_i;
`else
  assign npc  = seq_pc;
  assign pred = 1'b0;
  logic unused_bp;
  assign unused_bp = ^{bp_hit_i, bp_target_i};
`endif

  // Queue slots are reserved at issue time, so responses never need back-pressure.
  assign credit_ok = (32'(inflight) < MAX_OUTSTANDING) &&
                     ((32'(inflight) + 32'(count)) < IBUF_DEPTH);
  assign req_valid = !reset && !wfi_i && !exc_stall && (pc[1:0] == 2'b00) && credit_ok;
  assign req_fire  = req_valid && icache_req_ready_i;
  assign resp_fire = !reset && icache_resp_valid_i && (inflight != '0);
  assign resp_keep = resp_fire && !fl_kill[fl_head] && !redirect;
  assign exc_push  = !reset && !exc_stall && (pc[1:0] != 2'b00) && (inflight == '0) &&
                     (32'(count) < IBUF_DEPTH) && !redirect;
  assign q_push    = resp_keep || exc_push;
  assign q_pop     = !reset && (count != '0) && instr_ready_i;

  always_comb begin
    q_wdata = '0;
    if (exc_push) begin
      q_wdata.pc  = pc;
      q_wdata.npc = seq_pc;
      q_wdata.exc = 1'b1;
    end else begin
      q_wdata.pc   = fl_mem[fl_head].pc;
      q_wdata.npc  = fl_mem[fl_head].npc;
      q_wdata.data = icache_resp_data_i;
      q_wdata.pred = fl_mem[fl_head].pred;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) fl_mem[fl_tail] <= '{pc: pc, npc: npc, pred: pred};
    if (q_push)   q_mem[q_tail]   <= q_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      exc_stall <= 1'b0;
      fl_kill   <= '0;
      fl_head   <= '0;
      fl_tail   <= '0;
      inflight  <= '0;
      q_head    <= '0;
      q_tail    <= '0;
      count     <= '0;
    end else begin
      if (redirect)      pc <= target;
      else if (req_fire) pc <= npc;

      if (redirect)      exc_stall <= 1'b0;
      else if (exc_push) exc_stall <= 1'b1;

      // A request issued in a redirect cycle is born killed.
      if (redirect) fl_kill <= '1;
      if (req_fire) begin
        fl_kill[fl_tail] <= redirect;
        fl_tail          <= fl_next(fl_tail);
      end
      if (resp_fire) fl_head <= fl_next(fl_head);
      inflight <= inflight + IW'(req_fire) - IW'(resp_fire);

      if (redirect) begin
        q_head <= '0;
        q_tail <= '0;
        count  <= '0;
      end else begin
        if (q_push) q_tail <= q_tail + 1'b1;
        if (q_pop)  q_head <= q_head + 1'b1;
        count <= count + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  assign head                = q_mem[q_head];
  assign bp_pc_o             = pc;
  assign icache_req_valid_o  = req_valid;
  assign icache_req_addr_o   = pc;
  assign icache_resp_ready_o = !reset;
  assign instr_valid_o       = !reset && (count != '0);
  assign instr_pc_o          = head.pc;
  assign instr_next_pc_o     = head.npc;
  assign instr_o             = head.data;
  assign instr_pred_taken_o  = head.pred;
  assign instr_exc_o         = !reset && (count != '0) && head.exc;
  assign instr_ecause_o      = '0;
  assign ibuf_count_o        = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: streaming table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;
  localparam logic [31:0] RV = 32'h8000_0000;
  localparam int DEPTH = 8;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset, trap, mret, br, wfi, bp_hit, req_ready, resp_valid, instr_ready;
  logic [31:0] trap_vec, mret_vec, br_tgt, bp_target, resp_data;
  logic [31:0] bp_pc, req_addr, instr_pc, instr_npc, instr;
  logic        req_valid, resp_ready, instr_valid, instr_pred, instr_exc;
  logic [3:0]  instr_ecause, ibuf_count;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_VECTOR(RV), .IBUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .trap_i(trap), .trap_vector_i(trap_vec), .mret_i(mret), .mret_vector_i(mret_vec),
    .br_mispredict_i(br), .br_target_i(br_tgt), .wfi_i(wfi),
    .bp_pc_o(bp_pc), .bp_hit_i(bp_hit), .bp_target_i(bp_target),
    .icache_req_valid_o(req_valid), .icache_req_ready_i(req_ready), .icache_req_addr_o(req_addr),
    .icache_resp_valid_i(resp_valid), .icache_resp_ready_o(resp_ready), .icache_resp_data_i(resp_data),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_pc_o(instr_pc), .instr_next_pc_o(instr_npc), .instr_o(instr),
    .instr_pred_taken_o(instr_pred), .instr_exc_o(instr_exc), .instr_ecause_o(instr_ecause),
    .ibuf_count_o(ibuf_count)
  );

  typedef struct { logic [31:0] pc, npc; logic pred, kill; } fl_t;
  typedef struct { logic [31:0] pc, npc, data; logic pred, exc; } qe_t;
  typedef struct { logic exp_req; logic [31:0] exp_addr; logic exp_iv;
                   logic [31:0] exp_pc, exp_npc; int exp_cnt; } row_t;

  fl_t         m_if[$];
  qe_t         m_q[$];
  logic [31:0] m_pc;
  logic        m_stall;
  int          checks = 0, failures = 0;
  bit          auto_resp = 0, bp_auto = 0;
  logic [31:0] bp_at, bp_tgt;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] v = $urandom;
    if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic bit can_issue();
    return !reset && !wfi && !m_stall && (m_pc[1:0] == 2'b00) &&
           (m_if.size() < MAXO) && ((m_if.size() + m_q.size()) < DEPTH);
  endfunction

  task automatic idle();
    {trap, mret, br, wfi, bp_hit, resp_valid} = '0;
    {trap_vec, mret_vec, br_tgt, bp_target} = '0;
    req_ready = 1'b1;
    instr_ready = 1'b1;
  endtask

  // Finish driving the cycle's inputs, let them settle, compare outputs with the model.
  task automatic settle();
    if (bp_auto) begin
      bp_hit    = (m_pc == bp_at);
      bp_target = bp_tgt;
    end
    if (auto_resp) resp_valid = (m_if.size() != 0);
    resp_data = (m_if.size() != 0) ? fdata(m_if[0].pc) : 32'hDEAD_BEEF;
    #1;
    if (reset) begin
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_resp_ready", 32'(resp_ready), 0);
      chk("rst_instr_valid", 32'(instr_valid), 0);
    end else begin
      chk("req_valid", 32'(req_valid), 32'(can_issue()));
      if (can_issue()) chk("req_addr", req_addr, m_pc);
      chk("bp_pc", bp_pc, m_pc);
      chk("resp_ready", 32'(resp_ready), 1);
      chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("instr_pc", instr_pc, m_q[0].pc);
        chk("instr_npc", instr_npc, m_q[0].npc);
        chk("instr", instr, m_q[0].data);
        chk("instr_pred", 32'(instr_pred), 32'(m_q[0].pred));
        chk("instr_exc", 32'(instr_exc), 32'(m_q[0].exc));
        chk("instr_ecause", 32'(instr_ecause), 0);
      end
      chk("ibuf_count", 32'(ibuf_count), m_q.size());
    end
  endtask

  // Apply the clock edge to the reference model, then to the DUT.
  task automatic advance();
    logic        redirect, pred, fire, exc_push;
    logic [31:0] tgt, npc;
    fl_t         e;
    if (reset) begin
      m_pc = RV;
      m_stall = 1'b0;
      m_if.delete();
      m_q.delete();
    end else begin
      redirect = trap | mret | br;
      tgt = trap ? trap_vec : (mret ? mret_vec : br_tgt);
`ifdef FETCH_BP_EN
      npc  = bp_hit ? bp_target : m_pc + 32'd4;
      pred = bp_hit;
`else
      npc  = m_pc + 32'd4;
      pred = 1'b0;
`endif
      fire = can_issue() && req_ready;
      exc_push = !m_stall && (m_pc[1:0] != 2'b00) && (m_if.size() == 0) &&
                 (m_q.size() < DEPTH) && !redirect;
      if (instr_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (resp_valid && m_if.size() != 0) begin
        e = m_if.pop_front();
        if (!e.kill && !redirect) m_q.push_back('{e.pc, e.npc, resp_data, e.pred, 1'b0});
      end
      if (exc_push) begin
        m_q.push_back('{m_pc, m_pc + 32'd4, 32'd0, 1'b0, 1'b1});
        m_stall = 1'b1;
      end
      if (redirect) foreach (m_if[i]) m_if[i].kill = 1'b1;
      if (fire) m_if.push_back('{m_pc, npc, pred, redirect});
      if (redirect) begin
        m_q.delete();
        m_stall = 1'b0;
        m_pc = tgt;
      end else if (fire) begin
        m_pc = npc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic do_reset();
    idle();
    auto_resp = 1'b0;
    bp_auto = 1'b0;
    reset = 1'b1;
    cycle();
    settle();
    chk("reset_count", 32'(ibuf_count), 0);
    chk("reset_exc", 32'(instr_exc), 0);
    advance();
    reset = 1'b0;
  endtask

  // Wait (bounded) for the next valid queue head and check it; it is popped afterwards.
  task automatic wait_head(input string n, input logic [31:0] epc, input logic [31:0] enpc,
                           input logic epred, input logic eexc);
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      settle();
      if (instr_valid) begin
        found = 1;
        chk({n, "_pc"}, instr_pc, epc);
        chk({n, "_npc"}, instr_npc, enpc);
        chk({n, "_pred"}, 32'(instr_pred), 32'(epred));
        chk({n, "_exc"}, 32'(instr_exc), 32'(eexc));
        chk({n, "_ecause"}, 32'(instr_ecause), 0);
      end
      advance();
    end
    chk({n, "_seen"}, 32'(found), 1);
  endtask

  row_t stream[6];

  initial begin
    idle();
    reset = 1'b1;
    stream[0] = '{1'b1, RV,         1'b0, 32'h0,     32'h0,      0};
    stream[1] = '{1'b1, RV + 32'h4, 1'b0, 32'h0,     32'h0,      0};
    stream[2] = '{1'b1, RV + 32'h8, 1'b1, RV,        RV + 32'h4, 1};
    stream[3] = '{1'b1, RV + 32'hC, 1'b1, RV + 32'h4, RV + 32'h8, 1};
    stream[4] = '{1'b1, RV + 32'h10, 1'b1, RV + 32'h8, RV + 32'hC, 1};
    stream[5] = '{1'b1, RV + 32'h14, 1'b1, RV + 32'hC, RV + 32'h10, 1};

    // Streaming with 1-cycle I-cache latency and decode always ready.
    do_reset();
    auto_resp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("stream_req", 32'(req_valid), 32'(stream[i].exp_req));
      chk("stream_addr", req_addr, stream[i].exp_addr);
      chk("stream_iv", 32'(instr_valid), 32'(stream[i].exp_iv));
      if (stream[i].exp_iv) begin
        chk("stream_pc", instr_pc, stream[i].exp_pc);
        chk("stream_npc", instr_npc, stream[i].exp_npc);
      end
      chk("stream_cnt", 32'(ibuf_count), stream[i].exp_cnt);
      advance();
    end

    // Back-pressure: queue fills to IBUF_DEPTH, issue stops, then drains one per cycle.
    do_reset();
    auto_resp = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    settle();
    chk("bp_full_cnt", 32'(ibuf_count), DEPTH);
    chk("bp_full_req", 32'(req_valid), 0);
    chk("bp_full_pc", instr_pc, RV);
    instr_ready = 1'b1;
    advance();
    settle();
    chk("bp_drain_cnt", 32'(ibuf_count), DEPTH - 1);
    chk("bp_drain_req", 32'(req_valid), 1);
    chk("bp_drain_pc", instr_pc, RV + 32'h4);
    advance();
    for (int i = 0; i < 12; i++) cycle();

    // Kill: two requests in flight when a mispredict redirects.
    do_reset();
    resp_valid = 1'b0;
    cycle();
    cycle();
    settle();
    chk("kill_credit", 32'(req_valid), 0);
    br = 1'b1;
    br_tgt = 32'h8000_0100;
    advance();
    br = 1'b0;
    auto_resp = 1'b1;
    settle();
    chk("kill_iv", 32'(instr_valid), 0);
    chk("kill_addr", req_addr, 32'h8000_0100);
    advance();
    wait_head("kill", 32'h8000_0100, 32'h8000_0104, 1'b0, 1'b0);

    // Trap and mispredict together, with a response arriving in the same cycle.
    do_reset();
    auto_resp = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    trap = 1'b1;
    trap_vec = 32'h8000_0400;
    br = 1'b1;
    br_tgt = 32'h8000_0100;
    cycle();
    {trap, br} = '0;
    settle();
    chk("simul_iv", 32'(instr_valid), 0);
    chk("simul_addr", req_addr, 32'h8000_0400);
    advance();
    wait_head("simul", 32'h8000_0400, 32'h8000_0404, 1'b0, 1'b0);

    // Misaligned target: exception entry, then fetch halts until the next redirect.
    do_reset();
    auto_resp = 1'b1;
    cycle();
    cycle();
    br = 1'b1;
    br_tgt = 32'h8000_0102;
    cycle();
    br = 1'b0;
    settle();
    chk("mis_req", 32'(req_valid), 0);
    chk("mis_addr", req_addr, 32'h8000_0102);
    advance();
    wait_head("mis", 32'h8000_0102, 32'h8000_0106, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("mis_halt_req", 32'(req_valid), 0);
      chk("mis_halt_iv", 32'(instr_valid), 0);
      advance();
    end
    br = 1'b1;
    br_tgt = 32'h8000_0200;
    cycle();
    br = 1'b0;
    settle();
    chk("mis_resume_req", 32'(req_valid), 1);
    chk("mis_resume_addr", req_addr, 32'h8000_0200);
    advance();

    // PC wraps modulo 2^32.
    do_reset();
    auto_resp = 1'b1;
    cycle();
    br = 1'b1;
    br_tgt = 32'hFFFF_FFFC;
    cycle();
    br = 1'b0;
    wait_head("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    wait_head("wrap2", 32'h0, 32'h4, 1'b0, 1'b0);

    // Predictor hit at RV+8 targeting RV+0x40.
    do_reset();
    auto_resp = 1'b1;
    bp_auto = 1'b1;
    bp_at = RV + 32'h8;
    bp_tgt = RV + 32'h40;
    wait_head("pred0", RV, RV + 32'h4, 1'b0, 1'b0);
    wait_head("pred1", RV + 32'h4, RV + 32'h8, 1'b0, 1'b0);
`ifdef FETCH_BP_EN
    wait_head("pred2", RV + 32'h8, RV + 32'h40, 1'b1, 1'b0);
    wait_head("pred3", RV + 32'h40, RV + 32'h44, 1'b0, 1'b0);
`else
    wait_head("pred2", RV + 32'h8, RV + 32'hC, 1'b0, 1'b0);
    wait_head("pred3", RV + 32'hC, RV + 32'h10, 1'b0, 1'b0);
`endif
    bp_auto = 1'b0;

    // Randomized traffic, including mid-run resets and stray responses.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      trap        = ($urandom_range(0, 59) == 0);
      mret        = ($urandom_range(0, 59) == 0);
      br          = ($urandom_range(0, 24) == 0);
      trap_vec    = rand_tgt();
      mret_vec    = rand_tgt();
      br_tgt      = rand_tgt();
      wfi         = ($urandom_range(0, 9) == 0);
      bp_hit      = ($urandom_range(0, 4) == 0);
      bp_target   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      req_ready   = ($urandom_range(0, 9) < 7);
      resp_valid  = ($urandom_range(0, 9) < 6);
      instr_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
